dds_skew_wave: RTL and testbench
================================

DDS_SKEW_WAVE -- requirements
Module: dds_skew_wave

Interface
REQ-001 Parameter CHANNELS, default 4: number of time-multiplexed channels, range 1..16.
REQ-002 Parameter PHASE_W, default 18: phase, skew and slope word width.
REQ-003 Parameter OUT_W, default 19: output sample width.
REQ-004 Parameter FRAC, default 8: fractional bits dropped from the product, range 1..PHASE_W.
REQ-005 Clk  in  1  single clock; one clock; reset is synchronous and active-high.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Tick  in  1  sample-rate strobe; starts one sweep over all channels.
REQ-008 Cfg_Wr  in  1  configuration write strobe.
REQ-009 Cfg_Ch  in  4  target channel of the write.
REQ-010 Cfg_Addr  in  3  register select: 0 Freq, 1 Skew0, 2 Slope1, 3 Slope2, 4 Mode[1:0], 5 Phase preset.
REQ-011 Cfg_Data  in  PHASE_W  write data.
REQ-012 Valid  out  1  Output and Out_Ch are valid this cycle.
REQ-013 Out_Ch  out  4  channel of the current sample.
REQ-014 Output  out  OUT_W  sample value, unsigned.
REQ-015 Busy  out  1  sweep in progress.
REQ-016 Overrun  out  1  sticky flag: Tick arrived while Busy.

Function
REQ-017 Config writes SHALL go to per-channel shadow registers; Cfg_Ch >= CHANNELS or Cfg_Addr > 5 SHALL be ignored.
REQ-018 FSM states IDLE and SWEEP; IDLE + Tick -> SWEEP; SWEEP on the last channel issued -> IDLE.
REQ-019 On Tick accepted in IDLE, all shadow registers SHALL be committed to active registers in that cycle; a Cfg_Wr in the same cycle SHALL be included in the commit.
REQ-020 A committed Phase preset SHALL replace that channel's accumulator before the sweep uses it; the preset SHALL be consumed, not re-applied on later sweeps.
REQ-021 In SWEEP, one channel per clock SHALL be issued, in order 0..CHANNELS-1; the issued channel's sample uses its current phase x, then the phase updates to x+Freq mod 2^PHASE_W.
REQ-022 Tick while Busy SHALL be ignored and SHALL set Overrun; Overrun clears only on Reset.
REQ-023 Mode 0 (skewed triangle): if x > Skew0, p = (2^PHASE_W - x) mod 2^PHASE_W times Slope2, else p = x times Slope1; product width 2*PHASE_W.
REQ-024 Mode 1 (sawtooth): p = x times Slope1. Mode 2 (square): Output = all ones if x <= Skew0, else 0. Mode 3: Output = 0.
REQ-025 Modes 0/1: y = p[2*PHASE_W-1:FRAC] + p[FRAC-1] (round half up); if y >= 2^OUT_W, Output SHALL saturate to all ones, else Output = y[OUT_W-1:0].
REQ-026 Pipeline: issue, multiply, round/saturate; Valid SHALL assert exactly 3 cycles after the channel's issue cycle, one cycle per channel, contiguous.
REQ-027 Busy SHALL be high from the cycle after Tick is accepted until the last Valid of the sweep.

Reset
REQ-028 On Reset: FSM IDLE; all accumulators, active and shadow registers 0; pending presets cleared; pipeline flushed.
REQ-029 Reset outputs: Valid 0, Out_Ch 0, Output 0, Busy 0, Overrun 0.
REQ-030 Reset mid-sweep SHALL abort the sweep; no Valid SHALL follow it.

Structure
REQ-031 Shared package dds_pkg SHALL hold the Cfg_Addr constants, the Mode encodings, and the pipeline latency constant (3).
REQ-032 Per-sample arithmetic (select, multiply, round, saturate) SHALL be one sub-module, dds_skew_shape; the sequencer, register file and accumulators stay in the top level.

Verification
REQ-033 Defaults, ch0 Mode 0, Skew0=0x20000, Slope1=0x100, preset 0x10000, Tick -> ch0 Valid 3 cycles after issue, Output=65536.
REQ-034 Ch0 preset 0x30000, Slope2=0x200, Mode 0, Tick -> Output=131072 (falling branch).
REQ-035 Ch0 preset 0x1FFFF, Slope1=0x3FFFF, Tick -> Output=0x7FFFF (saturated); preset 1, Slope1=0x80 -> Output=1 (rounding).
REQ-036 Freq=0x10000, Mode 1, Slope1=0x100, four Ticks -> Outputs 0, 65536, 131072, 196608; Busy low between sweeps.
REQ-037 Tick, then Tick again 2 cycles later -> second Tick ignored, Overrun=1, exactly CHANNELS Valids; Reset mid-sweep -> Valid stays 0, all outputs 0.
REQ-038 Cfg_Wr Freq to ch1 in the Tick cycle -> the new Freq is applied in that sweep; Cfg_Ch=15 with CHANNELS=4 -> no register changes.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants for the skewed-wave DDS: config register map, waveform
// modes, sequencer states and the issue-to-output pipeline depth.
// Ports: none (package).
package dds_pkg;

    // Cfg_Addr register select
    localparam logic [2:0] CFG_FREQ   = 3'd0;
    localparam logic [2:0] CFG_SKEW0  = 3'd1;
    localparam logic [2:0] CFG_SLOPE1 = 3'd2;
    localparam logic [2:0] CFG_SLOPE2 = 3'd3;
    localparam logic [2:0] CFG_MODE   = 3'd4;
    localparam logic [2:0] CFG_PRESET = 3'd5;

    typedef enum logic [1:0] {
        MODE_TRI    = 2'd0,   // skewed triangle
        MODE_SAW    = 2'd1,   // sawtooth
        MODE_SQUARE = 2'd2,   // square, duty set by Skew0
        MODE_ZERO   = 2'd3    // muted
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // Cycles from a channel's issue cycle to its Valid
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/dds_skew_shape.sv
// Per-sample waveform shaping: branch select, multiply, round half up, saturate.
// Latency: PIPE_LAT (3) registered stages from the issue cycle to out_vld.
// No backpressure: one sample accepted per clock, always drains.
// Ports: clk/reset, in_* (issued channel and its active params + phase),
//        out_vld/out_ch/out_dat (finished sample), pipe_busy (any stage full).
module dds_skew_shape
    import dds_pkg::*;
#(
    parameter int PHASE_W = 18,
    parameter int OUT_W   = 19,
    parameter int FRAC    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_vld,
    input  logic [3:0]         in_ch,
    input  logic [PHASE_W-1:0] in_x,
    input  logic [PHASE_W-1:0] in_skew0,
    input  logic [PHASE_W-1:0] in_slope1,
    input  logic [PHASE_W-1:0] in_slope2,
    input  logic [1:0]         in_mode,
    output logic               out_vld,
    output logic [3:0]         out_ch,
    output logic [OUT_W-1:0]   out_dat,
    output logic               pipe_busy
);

    localparam int PW = 2 * PHASE_W;

    // stage A: captured issue
    logic               a_vld_q, a_vld_d;
    logic [3:0]         a_ch_q, a_ch_d;
    logic [PHASE_W-1:0] a_x_q, a_x_d, a_skew_q, a_skew_d;
    logic [PHASE_W-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [1:0]         a_mode_q, a_mode_d;
    // stage B: product
    logic               b_vld_q, b_vld_d, b_le_q, b_le_d;
    logic [3:0]         b_ch_q, b_ch_d;
    logic [1:0]         b_mode_q, b_mode_d;
    logic [PW-1:0]      b_prod_q, b_prod_d;
    // stage C: output
    logic               c_vld_q, c_vld_d;
    logic [3:0]         c_ch_q, c_ch_d;
    logic [OUT_W-1:0]   c_dat_q, c_dat_d;

    logic [PHASE_W-1:0] op, slope;
    logic [PW:0]        y;
    logic [PW+OUT_W:0]  y_ext;

    always_comb begin
        a_vld_d  = in_vld;
        a_ch_d   = in_ch;
        a_x_d    = in_x;
        a_skew_d = in_skew0;
        a_s1_d   = in_slope1;
        a_s2_d   = in_slope2;
        a_mode_d = in_mode;
    end

    always_comb begin
        b_le_d = (a_x_q <= a_skew_q);
        // Falling edge of the triangle counts down from the wrap point: 2^W - x.
        if (a_mode_q == MODE_TRI && !b_le_d) begin
            op    = PHASE_W'(0) - a_x_q;
            slope = a_s2_q;
        end else begin
            op    = a_x_q;
            slope = a_s1_q;
        end
        b_prod_d = PW'(op) * PW'(slope);
        b_vld_d  = a_vld_q;
        b_ch_d   = a_ch_q;
        b_mode_d = a_mode_q;
    end

    always_comb begin
        // Adding half an LSB before the shift == truncate plus bit FRAC-1.
        y     = ({1'b0, b_prod_q} + ((PW + 1)'(1) << (FRAC - 1))) >> FRAC;
        y_ext = (PW + OUT_W + 1)'(y);
        case (b_mode_q)
            MODE_TRI, MODE_SAW:
                c_dat_d = ((y_ext >> OUT_W) != '0) ? '1 : OUT_W'(y);
            MODE_SQUARE:
                c_dat_d = b_le_q ? '1 : '0;
            default:
                c_dat_d = '0;
        endcase
        c_vld_d = b_vld_q;
        c_ch_d  = b_ch_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_vld_q  <= 1'b0;
            a_ch_q   <= '0;
            a_x_q    <= '0;
            a_skew_q <= '0;
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            a_mode_q <= '0;
            b_vld_q  <= 1'b0;
            b_le_q   <= 1'b0;
            b_ch_q   <= '0;
            b_mode_q <= '0;
            b_prod_q <= '0;
            c_vld_q  <= 1'b0;
            c_ch_q   <= '0;
            c_dat_q  <= '0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_ch_q   <= a_ch_d;
            a_x_q    <= a_x_d;
            a_skew_q <= a_skew_d;
            a_s1_q   <= a_s1_d;
            a_s2_q   <= a_s2_d;
            a_mode_q <= a_mode_d;
            b_vld_q  <= b_vld_d;
            b_le_q   <= b_le_d;
            b_ch_q   <= b_ch_d;
            b_mode_q <= b_mode_d;
            b_prod_q <= b_prod_d;
            c_vld_q  <= c_vld_d;
            c_ch_q   <= c_ch_d;
            c_dat_q  <= c_dat_d;
        end
    end

    assign out_vld   = c_vld_q;
    assign out_ch    = c_ch_q;
    assign out_dat   = c_dat_q;
    assign pipe_busy = a_vld_q | b_vld_q | c_vld_q;

endmodule

// File: rtl/dds_skew_wave.sv
// Time-multiplexed skewed-wave DDS: shadow/active register file, phase
// accumulators and the IDLE/SWEEP sequencer; shaping lives in dds_skew_shape.
// Latency: Valid 3 cycles after each channel issue; Tick while Busy is dropped and flags Overrun.
// Ports: Clk/Reset, Tick, Cfg_* write port, Valid/Out_Ch/Output sample, Busy, Overrun.
module dds_skew_wave
    import dds_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PHASE_W  = 18,
    parameter int OUT_W    = 19,
    parameter int FRAC     = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Tick,
    input  logic               Cfg_Wr,
    input  logic [3:0]         Cfg_Ch,
    input  logic [2:0]         Cfg_Addr,
    input  logic [PHASE_W-1:0] Cfg_Data,
    output logic               Valid,
    output logic [3:0]         Out_Ch,
    output logic [OUT_W-1:0]   Output,
    output logic               Busy,
    output logic               Overrun
);

    typedef logic [PHASE_W-1:0] word_t;

    word_t sh_freq_q [CHANNELS], sh_freq_d [CHANNELS];
    word_t sh_skew_q [CHANNELS], sh_skew_d [CHANNELS];
    word_t sh_s1_q   [CHANNELS], sh_s1_d   [CHANNELS];
    word_t sh_s2_q   [CHANNELS], sh_s2_d   [CHANNELS];
    word_t sh_pre_q  [CHANNELS], sh_pre_d  [CHANNELS];
    logic [1:0] sh_mode_q [CHANNELS], sh_mode_d [CHANNELS];
    logic [CHANNELS-1:0] sh_pend_q, sh_pend_d;

    word_t act_freq_q [CHANNELS], act_freq_d [CHANNELS];
    word_t act_skew_q [CHANNELS], act_skew_d [CHANNELS];
    word_t act_s1_q   [CHANNELS], act_s1_d   [CHANNELS];
    word_t act_s2_q   [CHANNELS], act_s2_d   [CHANNELS];
    logic [1:0] act_mode_q [CHANNELS], act_mode_d [CHANNELS];
    word_t acc_q [CHANNELS], acc_d [CHANNELS];

    state_e     state_q, state_d;
    logic [3:0] ch_q, ch_d;
    logic       overrun_q, overrun_d;

    logic       wr_ok, tick_acc, iss_vld, pipe_busy;
    word_t      iss_x, iss_skew, iss_s1, iss_s2;
    logic [1:0] iss_mode;

    // state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            overrun_q <= overrun_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        ch_d    = '0;
        case (state_q)
            ST_IDLE:  if (tick_acc) state_d = ST_SWEEP;
            ST_SWEEP: begin
                if (ch_q == 4'(CHANNELS - 1)) state_d = ST_IDLE;
                else                          ch_d    = ch_q + 4'd1;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // outputs: Busy spans the sweep plus the pipeline drain
    always_comb begin
        iss_vld   = (state_q == ST_SWEEP);
        Busy      = iss_vld | pipe_busy;
        tick_acc  = Tick & ~Busy;
        overrun_d = overrun_q | (Tick & Busy);
    end

    // register file, commit and accumulators
    always_comb begin
        wr_ok      = Cfg_Wr && (32'(Cfg_Ch) < CHANNELS) && (Cfg_Addr <= CFG_PRESET);
        sh_freq_d  = sh_freq_q;
        sh_skew_d  = sh_skew_q;
        sh_s1_d    = sh_s1_q;
        sh_s2_d    = sh_s2_q;
        sh_pre_d   = sh_pre_q;
        sh_mode_d  = sh_mode_q;
        sh_pend_d  = sh_pend_q;
        act_freq_d = act_freq_q;
        act_skew_d = act_skew_q;
        act_s1_d   = act_s1_q;
        act_s2_d   = act_s2_q;
        act_mode_d = act_mode_q;
        acc_d      = acc_q;
        iss_x      = '0;
        iss_skew   = '0;
        iss_s1     = '0;
        iss_s2     = '0;
        iss_mode   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ok && Cfg_Ch == 4'(c)) begin
                case (Cfg_Addr)
                    CFG_FREQ:   sh_freq_d[c] = Cfg_Data;
                    CFG_SKEW0:  sh_skew_d[c] = Cfg_Data;
                    CFG_SLOPE1: sh_s1_d[c]   = Cfg_Data;
                    CFG_SLOPE2: sh_s2_d[c]   = Cfg_Data;
                    CFG_MODE:   sh_mode_d[c] = Cfg_Data[1:0];
                    default: begin
                        sh_pre_d[c]  = Cfg_Data;
                        sh_pend_d[c] = 1'b1;
                    end
                endcase
            end
            // Commit sees this cycle's write; a pending preset lands in the
            // accumulator now and is then forgotten.
            if (tick_acc) begin
                act_freq_d[c] = sh_freq_d[c];
                act_skew_d[c] = sh_skew_d[c];
                act_s1_d[c]   = sh_s1_d[c];
                act_s2_d[c]   = sh_s2_d[c];
                act_mode_d[c] = sh_mode_d[c];
                if (sh_pend_d[c]) acc_d[c] = sh_pre_d[c];
            end
            if (iss_vld && ch_q == 4'(c)) begin
                iss_x    = acc_q[c];
                iss_skew = act_skew_q[c];
                iss_s1   = act_s1_q[c];
                iss_s2   = act_s2_q[c];
                iss_mode = act_mode_q[c];
                acc_d[c] = acc_q[c] + act_freq_q[c];
            end
        end
        if (tick_acc) sh_pend_d = '0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_freq_q  <= '{default: '0};
            sh_skew_q  <= '{default: '0};
            sh_s1_q    <= '{default: '0};
            sh_s2_q    <= '{default: '0};
            sh_pre_q   <= '{default: '0};
            sh_mode_q  <= '{default: '0};
            sh_pend_q  <= '0;
            act_freq_q <= '{default: '0};
            act_skew_q <= '{default: '0};
            act_s1_q   <= '{default: '0};
            act_s2_q   <= '{default: '0};
            act_mode_q <= '{default: '0};
            acc_q      <= '{default: '0};
        end else begin
            sh_freq_q  <= sh_freq_d;
            sh_skew_q  <= sh_skew_d;
            sh_s1_q    <= sh_s1_d;
            sh_s2_q    <= sh_s2_d;
            sh_pre_q   <= sh_pre_d;
            sh_mode_q  <= sh_mode_d;
            sh_pend_q  <= sh_pend_d;
            act_freq_q <= act_freq_d;
            act_skew_q <= act_skew_d;
            act_s1_q   <= act_s1_d;
            act_s2_q   <= act_s2_d;
            act_mode_q <= act_mode_d;
            acc_q      <= acc_d;
        end
    end

    dds_skew_shape #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W),
        .FRAC    (FRAC)
    ) u_shape (
        .clk       (Clk),
        .reset     (Reset),
        .in_vld    (iss_vld),
        .in_ch     (ch_q),
        .in_x      (iss_x),
        .in_skew0  (iss_skew),
        .in_slope1 (iss_s1),
        .in_slope2 (iss_s2),
        .in_mode   (iss_mode),
        .out_vld   (Valid),
        .out_ch    (Out_Ch),
        .out_dat   (Output),
        .pipe_busy (pipe_busy)
    );

    assign Overrun = overrun_q;

endmodule

// File: tb/tb_dds_skew_wave.sv
module tb_dds_skew_wave;

    localparam int CH = 4;
    localparam int PW = 18;
    localparam int OW = 19;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          cfg_wr = 1'b0;
    logic [3:0]    cfg_ch = '0;
    logic [2:0]    cfg_addr = '0;
    logic [PW-1:0] cfg_data = '0;
    logic          valid;
    logic [3:0]    out_ch;
    logic [OW-1:0] out_dat;
    logic          busy;
    logic          overrun;

    dds_skew_wave #(.CHANNELS(CH), .PHASE_W(PW), .OUT_W(OW), .FRAC(8)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Tick     (tick),
        .Cfg_Wr   (cfg_wr),
        .Cfg_Ch   (cfg_ch),
        .Cfg_Addr (cfg_addr),
        .Cfg_Data (cfg_data),
        .Valid    (valid),
        .Out_Ch   (out_ch),
        .Output   (out_dat),
        .Busy     (busy),
        .Overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    ch;
        logic [OW-1:0] dat;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic [PW-1:0] skew;
        logic [PW-1:0] s1;
        logic [PW-1:0] s2;
        logic [PW-1:0] pre;
        logic [OW-1:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[11];
    int   tests = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tick_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every Valid must match the oldest expectation, arrive in
    // channel order and land exactly 4+ch cycles after the Tick was driven.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("out_ch", 32'(out_ch), 32'(mon_e.ch));
                check("output", 32'(out_dat), 32'(mon_e.dat));
                check("valid_timing", 32'(cyc - tick_cyc), 32'(4 + int'(mon_e.ch)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [2:0] addr, input logic [PW-1:0] data);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_addr = addr; cfg_data = data;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic push_sweep(input logic [OW-1:0] v0, input logic [OW-1:0] v1);
        for (int c = 0; c < CH; c++) begin
            exp_t e;
            e.ch  = 4'(c);
            e.dat = (c == 0) ? v0 : (c == 1) ? v1 : '0;
            sb.push_back(e);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        tick_cyc = cyc;
        step();
        tick = 1'b0;
    endtask

    // Waits for Busy to drop; the wait length pins down when Busy falls.
    task automatic wait_sweep(input int exp_len);
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("busy_len", 32'(n), 32'(exp_len));
        check("sb_drained", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    initial begin
        //            mode  skew      slope1    slope2   preset    expected
        vecs[0]  = '{2'd0, 18'h20000, 18'h00100, 18'h000, 18'h10000, 19'd65536};
        vecs[1]  = '{2'd0, 18'h20000, 18'h00100, 18'h200, 18'h30000, 19'd131072};
        vecs[2]  = '{2'd0, 18'h20000, 18'h3FFFF, 18'h200, 18'h1FFFF, 19'h7FFFF};
        vecs[3]  = '{2'd0, 18'h20000, 18'h00080, 18'h200, 18'h00001, 19'd1};
        vecs[4]  = '{2'd0, 18'h20000, 18'h00100, 18'h200, 18'h20000, 19'd131072};
        vecs[5]  = '{2'd0, 18'h20000, 18'h00100, 18'h200, 18'h20001, 19'd262142};
        vecs[6]  = '{2'd2, 18'h20000, 18'h00100, 18'h200, 18'h20000, 19'h7FFFF};
        vecs[7]  = '{2'd2, 18'h20000, 18'h00100, 18'h200, 18'h20001, 19'd0};
        vecs[8]  = '{2'd3, 18'h20000, 18'h00100, 18'h200, 18'h10000, 19'd0};
        vecs[9]  = '{2'd1, 18'h20000, 18'h0007F, 18'h200, 18'h00001, 19'd0};
        vecs[10] = '{2'd1, 18'h20000, 18'h00200, 18'h200, 18'h3FFFF, 19'h7FFFE};

        repeat (3) step();
        reset = 1'b0;
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_out_ch", 32'(out_ch), 32'(0));
        check("rst_output", 32'(out_dat), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));

        // Single-sweep shapes on ch0; other channels stay at reset config (0)
        for (int i = 0; i < 11; i++) begin
            cfg(4'd0, 3'd1, vecs[i].skew);
            cfg(4'd0, 3'd2, vecs[i].s1);
            cfg(4'd0, 3'd3, vecs[i].s2);
            cfg(4'd0, 3'd4, PW'(vecs[i].mode));
            cfg(4'd0, 3'd5, vecs[i].pre);
            push_sweep(vecs[i].exp, '0);
            do_tick();
            check("busy_after_tick", 32'(busy), 32'(1));
            wait_sweep(CH + 3);
        end

        // Sawtooth over four sweeps; preset applied once only
        cfg(4'd0, 3'd0, 18'h10000);
        cfg(4'd0, 3'd4, 18'd1);
        cfg(4'd0, 3'd2, 18'h00100);
        cfg(4'd0, 3'd5, 18'h00000);
        for (int k = 0; k < 4; k++) begin
            push_sweep(OW'(k * 65536), '0);
            do_tick();
            wait_sweep(CH + 3);
            step();
            check("busy_between", 32'(busy), 32'(0));
        end

        // Freq write to ch1 in the Tick cycle is part of that commit
        cfg(4'd0, 3'd0, 18'h0);
        cfg(4'd0, 3'd5, 18'h0);
        cfg(4'd1, 3'd4, 18'd1);
        cfg(4'd1, 3'd2, 18'h00100);
        push_sweep('0, '0);
        cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_addr = 3'd0; cfg_data = 18'h08000;
        do_tick();
        cfg_wr = 1'b0;
        wait_sweep(CH + 3);
        push_sweep('0, 19'd32768);
        do_tick();
        wait_sweep(CH + 3);

        // Out-of-range channel and register addresses change nothing
        cfg(4'd15, 3'd0, 18'h3FFFF);
        cfg(4'd15, 3'd5, 18'h3FFFF);
        cfg(4'd0, 3'd6, 18'h3FFFF);
        cfg(4'd1, 3'd7, 18'h00001);
        push_sweep('0, 19'd65536);
        do_tick();
        wait_sweep(CH + 3);

        // Tick while Busy: ignored, Overrun sticky, exactly CH Valids
        cfg(4'd1, 3'd0, 18'h0);
        cfg(4'd1, 3'd5, 18'h0);
        check("overrun_pre", 32'(overrun), 32'(0));
        push_sweep('0, '0);
        do_tick();
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("overrun_set", 32'(overrun), 32'(1));
        wait_sweep(CH + 1);
        repeat (3) step();
        check("overrun_sticky", 32'(overrun), 32'(1));

        // Reset mid-sweep: sweep aborted, no Valid afterwards
        do_tick();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_overrun", 32'(overrun), 32'(0));
        for (int k = 0; k < 8; k++) begin
            check("mid_rst_valid", 32'(valid), 32'(0));
            check("mid_rst_output", 32'(out_dat), 32'(0));
            check("mid_rst_out_ch", 32'(out_ch), 32'(0));
            step();
        end

        // Accumulators were cleared by reset: ch0 restarts at phase 0
        cfg(4'd0, 3'd4, 18'd1);
        cfg(4'd0, 3'd2, 18'h00100);
        push_sweep('0, '0);
        do_tick();
        wait_sweep(CH + 3);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
